decim_sequencer: RTL and testbench

- Run controller for one decimation channel's accumulator datapath.
- Latches a downsampling ratio and starts and stops the accumulation run.
- Generates the accumulate-enable window and dump/clear strobes, and discards the first settling frames.
- Hands each decimated sample downstream over a valid/ready interface with overrun detection. Sits between the register interface and the accumulator/output FIFO.

---
 rtl/decim_pkg.sv | 13 +
 rtl/decim_frame_counter.sv | 42 ++++
 rtl/decim_sequencer.sv | 146 ++++++++++++++
 tb/tb_decim_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decim_pkg.sv
// Shared types and constants for the decimation run controller.
package decim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN,
        DRAIN
    } state_t;

    localparam int unsigned MIN_RATIO = 2;

endpackage

// File: rtl/decim_frame_counter.sv
// Frame position counter: counts 1..ratio while running, flags the dump
// cycle and opens the accumulate window for the leading WINDOW counts.
module decim_frame_counter
    import decim_pkg::*;
#(
    parameter int unsigned ACCUMULATIONS_WIDTH = 16,
    parameter int unsigned WINDOW              = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  state_t                         state,
    input  logic                           load,
    input  logic [ACCUMULATIONS_WIDTH-1:0] ratio,
    output logic                           dump,
    output logic                           acc_en
);

    localparam int unsigned AW = ACCUMULATIONS_WIDTH;
    localparam logic [AW-1:0] WIN = AW'(WINDOW);

    logic [AW-1:0] count;
    logic          running;

    always_comb begin
        running = (state != IDLE);
        dump    = running && (count == ratio);
        acc_en  = running && (count <= WIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= AW'(1);
        end else if (running) begin
            count <= dump ? AW'(1) : count + AW'(1);
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/decim_sequencer.sv
// Run controller for one decimation channel: ratio shadow, settle discard,
// accumulate window/dump strobes and a valid/ready sample register.
// Optional frame index output enabled by DECIM_SEQ_FRAME_IDX_EN.
module decim_sequencer
    import decim_pkg::*;
#(
    parameter int unsigned ACCUMULATIONS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH          = 24,
    parameter int unsigned WINDOW              = 8,
    parameter int unsigned SETTLE_DUMPS        = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ACCUMULATIONS_WIDTH-1:0] cfg_ratio,
    input  logic                           start,
    input  logic                           stop,
    input  logic [DATA_WIDTH-1:0]          acc_data,
    output logic                           acc_en,
    output logic                           acc_clr,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           cfg_err,
    output logic                           overrun
`ifdef DECIM_SEQ_FRAME_IDX_EN
    ,
    output logic [31:0]                    out_idx
`endif
);

    localparam int unsigned AW = ACCUMULATIONS_WIDTH;
    localparam int unsigned SW = $clog2(SETTLE_DUMPS + 2);
    localparam logic [AW-1:0] MIN_R = AW'(MIN_RATIO);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_DUMPS - 1);

    state_t        state, state_next;
    logic [AW-1:0] ratio_q;
    logic [SW-1:0] settle_cnt;
    logic          drain_from_run;
    logic          dump;
    logic          start_ok, start_bad, settle_done, emit, handshake;

    decim_frame_counter #(
        .ACCUMULATIONS_WIDTH(AW),
        .WINDOW             (WINDOW)
    ) u_frame_counter (
        .clk   (clk),
        .reset (reset),
        .state (state),
        .load  (start_ok),
        .ratio (ratio_q),
        .dump  (dump),
        .acc_en(acc_en)
    );

    always_comb begin
        start_ok    = (state == IDLE) && start && (cfg_ratio >= MIN_R);
        start_bad   = (state == IDLE) && start && (cfg_ratio < MIN_R);
        settle_done = dump && (settle_cnt == SETTLE_LAST);
        // DRAIN only emits when the run had already left SETTLE
        emit        = dump && ((state == RUN) || ((state == DRAIN) && drain_from_run));
        handshake   = out_valid && out_ready;
        acc_clr     = dump;
        busy        = (state != IDLE);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_ok) state_next = (SETTLE_DUMPS == 0) ? RUN : SETTLE;
            end
            SETTLE: begin
                if (dump && stop)     state_next = IDLE;
                else if (settle_done) state_next = RUN;
                else if (stop)        state_next = DRAIN;
            end
            RUN: begin
                if (dump && stop) state_next = IDLE;
                else if (stop)    state_next = DRAIN;
            end
            DRAIN: begin
                if (dump) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            ratio_q        <= '0;
            settle_cnt     <= '0;
            drain_from_run <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                ratio_q    <= cfg_ratio;
                settle_cnt <= '0;
                cfg_err    <= 1'b0;
            end else if (start_bad) begin
                cfg_err <= 1'b1;
            end
            if ((state == SETTLE) && dump) settle_cnt <= settle_cnt + SW'(1);
            if (state_next == DRAIN && state != DRAIN) drain_from_run <= (state == RUN);
        end
    end

`ifdef DECIM_SEQ_FRAME_IDX_EN
    logic [31:0] emit_cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef DECIM_SEQ_FRAME_IDX_EN
            out_idx   <= '0;
            emit_cnt  <= '0;
`endif
        end else begin
            if (start_ok) begin
                overrun <= 1'b0;
`ifdef DECIM_SEQ_FRAME_IDX_EN
                emit_cnt <= '0;
`endif
            end
            if (emit && (!out_valid || out_ready)) begin
                out_data  <= acc_data;
                out_valid <= 1'b1;
`ifdef DECIM_SEQ_FRAME_IDX_EN
                out_idx   <= emit_cnt;
                emit_cnt  <= emit_cnt + 32'd1;
`endif
            end else if (emit) begin
                overrun <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decim_sequencer.sv
// Randomized self-checking bench for decim_sequencer against a frame-level
// reference model (run position, stop frame, single output slot).
module tb_decim_sequencer;

    localparam int AW = 16;
    localparam int DW = 24;
    localparam int WIN = 8;
    localparam int SD = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cfg_ratio;
    logic          start, stop, out_ready;
    logic [DW-1:0] acc_data;
    logic          acc_en, acc_clr, out_valid, busy, cfg_err, overrun;
    logic [DW-1:0] out_data;
`ifdef DECIM_SEQ_FRAME_IDX_EN
    logic [31:0]   out_idx;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    decim_sequencer #(
        .ACCUMULATIONS_WIDTH(AW),
        .DATA_WIDTH         (DW),
        .WINDOW             (WIN),
        .SETTLE_DUMPS       (SD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_ratio(cfg_ratio),
        .start    (start),
        .stop     (stop),
        .acc_data (acc_data),
        .acc_en   (acc_en),
        .acc_clr  (acc_clr),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .cfg_err  (cfg_err),
        .overrun  (overrun)
`ifdef DECIM_SEQ_FRAME_IDX_EN
        ,
        .out_idx  (out_idx)
`endif
    );

    // Reference model: t = cycles since accepted start, frame = t / ratio.
    bit            m_active, m_cfg_err, m_overrun, m_valid;
    int            m_t, m_ratio, m_stop_frame;
    logic [DW-1:0] m_data;
    int unsigned   m_idx, m_emit_cnt;

    function automatic bit exp_clr();
        if (!m_active) return 1'b0;
        return (m_t % m_ratio) == (m_ratio - 1);
    endfunction

    function automatic bit exp_en();
        if (!m_active) return 1'b0;
        return ((m_t % m_ratio) + 1) <= WIN;
    endfunction

    task automatic model_reset();
        m_active = 0; m_cfg_err = 0; m_overrun = 0; m_valid = 0;
        m_t = 0; m_ratio = 0; m_stop_frame = -1;
        m_data = '0; m_idx = 0; m_emit_cnt = 0;
    endtask

    task automatic cycle();
        bit n_active = m_active, n_cfg = m_cfg_err, n_ovr = m_overrun, n_valid = m_valid;
        int n_t = m_t, n_ratio = m_ratio, n_stop = m_stop_frame, f;
        logic [DW-1:0] n_data = m_data;
        int unsigned n_idx = m_idx, n_cnt = m_emit_cnt;
        bit dmp = exp_clr();
        bit hs = m_valid && out_ready;
        bit emit = 0;
        if (!m_active) begin
            if (start) begin
                if (cfg_ratio >= 2) begin
                    n_active = 1; n_t = 0; n_ratio = int'(cfg_ratio); n_stop = -1;
                    n_cfg = 0; n_ovr = 0; n_cnt = 0;
                end else begin
                    n_cfg = 1;
                end
            end
        end else begin
            f = m_t / m_ratio;
            if (stop && n_stop < 0) n_stop = f;
            emit = dmp && (f >= SD);
            if (dmp && n_stop == f) n_active = 0;
            else n_t = m_t + 1;
        end
        if (emit) begin
            if (!m_valid || hs) begin
                n_valid = 1; n_data = acc_data; n_idx = m_emit_cnt; n_cnt = m_emit_cnt + 1;
            end else begin
                n_ovr = 1;
            end
        end else if (hs) begin
            n_valid = 0;
        end
        @(posedge clk);
        m_active = n_active; m_cfg_err = n_cfg; m_overrun = n_ovr; m_valid = n_valid;
        m_t = n_t; m_ratio = n_ratio; m_stop_frame = n_stop;
        m_data = n_data; m_idx = n_idx; m_emit_cnt = n_cnt;
        #1;
        start = 0; stop = 0;
        acc_data = DW'($urandom);
        cfg_ratio = AW'($urandom_range(0, 12));
        @(negedge clk);
    endtask

    task automatic return_idle();
        stop = 1;
        cycle();
        for (int i = 0; i < 40 && m_active; i++) cycle();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got %b expected 0", busy); end
    endtask

    task automatic test_reset();
        total++;
        if ({busy, out_valid, cfg_err, overrun, acc_en, acc_clr} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got %b expected 000000", {busy, out_valid, cfg_err, overrun, acc_en, acc_clr});
        end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL reset_data got %h expected 0", out_data); end
    endtask

    task automatic test_basic();
        int clr_n = 0, val_n = 0;
        out_ready = 1; cfg_ratio = 4; start = 1;
        cycle();
        for (int i = 0; i < 28; i++) begin
            total++;
            if (acc_clr !== exp_clr()) begin bad++; $display("FAIL basic_clr t=%0d got %b expected %b", m_t, acc_clr, exp_clr()); end
            total++;
            if (acc_en !== exp_en()) begin bad++; $display("FAIL basic_en t=%0d got %b expected %b", m_t, acc_en, exp_en()); end
            total++;
            if (busy !== m_active) begin bad++; $display("FAIL basic_busy t=%0d got %b expected %b", m_t, busy, m_active); end
            total++;
            if (out_valid !== m_valid) begin bad++; $display("FAIL basic_valid t=%0d got %b expected %b", m_t, out_valid, m_valid); end
            total++;
            if (out_valid && out_data !== m_data) begin bad++; $display("FAIL basic_data t=%0d got %h expected %h", m_t, out_data, m_data); end
            clr_n += int'(acc_clr);
            val_n += int'(out_valid);
            cycle();
        end
        total++;
        if (clr_n != 7) begin bad++; $display("FAIL basic_clr_count got %0d expected 7", clr_n); end
        total++;
        if (val_n != 4) begin bad++; $display("FAIL basic_valid_count got %0d expected 4", val_n); end
        return_idle();
    endtask

    task automatic test_cfg_err();
        int en_n = 0;
        cfg_ratio = 1; start = 1;
        cycle();
        total++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL err_ratio1 got err=%b busy=%b expected err=1 busy=0", cfg_err, busy); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (acc_clr !== 1'b0) begin bad++; $display("FAIL err_clr got %b expected 0", acc_clr); end
            cycle();
        end
        cfg_ratio = 0; start = 1;
        cycle();
        total++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL err_ratio0 got err=%b busy=%b expected err=1 busy=0", cfg_err, busy); end
        cfg_ratio = 10; start = 1;
        cycle();
        total++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL err_clear got err=%b busy=%b expected err=0 busy=1", cfg_err, busy); end
        for (int i = 0; i < 30; i++) begin
            total++;
            if (acc_en !== exp_en()) begin bad++; $display("FAIL win_en t=%0d got %b expected %b", m_t, acc_en, exp_en()); end
            en_n += int'(acc_en);
            cycle();
        end
        total++;
        if (en_n != 24) begin bad++; $display("FAIL win_en_count got %0d expected 24", en_n); end
        out_ready = 1;
        return_idle();
    endtask

    task automatic test_overrun();
        out_ready = 1; cfg_ratio = 3; start = 1;
        cycle();
        repeat (6) cycle();
        out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== m_valid || overrun !== m_overrun) begin
                bad++; $display("FAIL ovr_hold t=%0d got v=%b o=%b expected v=%b o=%b", m_t, out_valid, overrun, m_valid, m_overrun);
            end
            cycle();
        end
        total++;
        if (overrun !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL ovr_flag got o=%b v=%b expected o=1 v=1", overrun, out_valid); end
        total++;
        if (out_data !== m_data) begin bad++; $display("FAIL ovr_first_data got %h expected %h", out_data, m_data); end
        out_ready = 1;
        cycle();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got %b expected 0", out_valid); end
        for (int i = 0; i < 40; i++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            total++;
            if (out_valid !== m_valid || overrun !== m_overrun) begin
                bad++; $display("FAIL ovr_rand t=%0d got v=%b o=%b expected v=%b o=%b", m_t, out_valid, overrun, m_valid, m_overrun);
            end
            total++;
            if (out_valid && out_data !== m_data) begin bad++; $display("FAIL ovr_rand_data got %h expected %h", out_data, m_data); end
            cycle();
        end
        out_ready = 1;
        return_idle();
    endtask

    task automatic test_stop();
        out_ready = 1; cfg_ratio = 6; start = 1;
        cycle();
        repeat (18) cycle();
        stop = 1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (busy !== 1'b1 || acc_clr !== exp_clr()) begin
                bad++; $display("FAIL drain_busy step=%0d got busy=%b clr=%b expected busy=1 clr=%b", i, busy, acc_clr, exp_clr());
            end
            cycle();
        end
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL drain_end got busy=%b v=%b expected busy=0 v=1", busy, out_valid); end
        total++;
        if (out_data !== m_data) begin bad++; $display("FAIL drain_data got %h expected %h", out_data, m_data); end
        cfg_ratio = 6; start = 1;
        cycle();
        repeat (17) cycle();
        stop = 1;
        cycle();
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL stop_on_dump got busy=%b v=%b expected busy=0 v=1", busy, out_valid); end
        total++;
        if (out_data !== m_data) begin bad++; $display("FAIL stop_on_dump_data got %h expected %h", out_data, m_data); end
        cycle();
    endtask

    task automatic test_reset_midrun();
        out_ready = 0; cfg_ratio = 4; start = 1;
        cycle();
        repeat (14) cycle();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got %b expected 1", out_valid); end
        #2 reset = 0;
        #1;
        total++;
        if ({busy, out_valid, cfg_err, overrun, acc_en, acc_clr} !== 6'b0) begin
            bad++; $display("FAIL async_reset_flags got %b expected 000000", {busy, out_valid, cfg_err, overrun, acc_en, acc_clr});
        end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL async_reset_data got %h expected 0", out_data); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        test_basic();
    endtask

`ifdef DECIM_SEQ_FRAME_IDX_EN
    task automatic test_idx();
        int seen = 0;
        out_ready = 1; cfg_ratio = 2; start = 1;
        cycle();
        for (int i = 0; i < 11; i++) begin
            if (out_valid) begin
                total++;
                if (out_idx !== 32'(seen)) begin bad++; $display("FAIL idx_seq got %0d expected %0d", out_idx, seen); end
                seen++;
            end
            cycle();
        end
        out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_idx !== m_idx) begin bad++; $display("FAIL idx_drop got %0d expected %0d", out_idx, m_idx); end
            cycle();
        end
        out_ready = 1;
        return_idle();
        cycle();
        cfg_ratio = 2; start = 1;
        cycle();
        repeat (6) cycle();
        total++;
        if (out_valid !== 1'b1 || out_idx !== 32'd0) begin bad++; $display("FAIL idx_restart got v=%b idx=%0d expected v=1 idx=0", out_valid, out_idx); end
        return_idle();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 9) == 0);
            stop = ($urandom_range(0, 14) == 0);
            total++;
            if ({acc_clr, acc_en, busy} !== {exp_clr(), exp_en(), m_active}) begin
                bad++; $display("FAIL rand_ctrl i=%0d got %b expected %b", i, {acc_clr, acc_en, busy}, {exp_clr(), exp_en(), m_active});
            end
            total++;
            if ({out_valid, overrun, cfg_err} !== {m_valid, m_overrun, m_cfg_err}) begin
                bad++; $display("FAIL rand_flags i=%0d got %b expected %b", i, {out_valid, overrun, cfg_err}, {m_valid, m_overrun, m_cfg_err});
            end
            total++;
            if (out_data !== m_data) begin bad++; $display("FAIL rand_data i=%0d got %h expected %h", i, out_data, m_data); end
`ifdef DECIM_SEQ_FRAME_IDX_EN
            total++;
            if (out_idx !== m_idx) begin bad++; $display("FAIL rand_idx i=%0d got %0d expected %0d", i, out_idx, m_idx); end
`endif
            cycle();
        end
    endtask

    initial begin
        reset = 0; start = 0; stop = 0; out_ready = 0;
        cfg_ratio = '0; acc_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_cfg_err();
        test_overrun();
        test_stop();
        test_reset_midrun();
`ifdef DECIM_SEQ_FRAME_IDX_EN
        test_idx();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
